// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU control unit. Sequences fetch/decode/execute/
// memory/write-back one micro-step per clock, stalls on the memory handshake
// and takes external interrupts between instructions. Drives only datapath
// selects and write enables; holds no datapath state of its own.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       MIO_ready,
    input  logic       INT,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       CPU_MIO,
    output logic       IRWrite,
    output logic       EPCWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUop,
    output logic [2:0] PCSource,
    output logic       signal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IF   = 4'd0,  ST_ID   = 4'd1,  ST_MADR = 4'd2,  ST_MRD  = 4'd3,
        ST_LWB  = 4'd4,  ST_MWR  = 4'd5,  ST_REX  = 4'd6,  ST_RWB  = 4'd7,
        ST_BR   = 4'd8,  ST_JMP  = 4'd9,  ST_IEX  = 4'd10, ST_IWB  = 4'd11,
        ST_JAL  = 4'd12, ST_JR   = 4'd13, ST_ERET = 4'd14, ST_INTR = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ERET  = 6'b011000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t r_state;
    state_t w_next;
    logic   r_int_en;
    logic   r_int_pending;

    // R-type funct field to ALU operation; unknown functs fall back to add.
    function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            6'b100000: op = ALU_ADD;
            6'b100010: op = ALU_SUB;
            6'b100100: op = ALU_AND;
            6'b100101: op = ALU_OR;
            6'b100110: op = ALU_XOR;
            6'b100111: op = ALU_NOR;
            6'b101010: op = ALU_SLT;
            6'b000010: op = ALU_SRL;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Immediate-ALU opcode to ALU operation.
    function automatic logic [2:0] alu_from_opcode(input logic [5:0] op_in);
        logic [2:0] op;
        case (op_in)
            OP_SLTI: op = ALU_SLT;
            OP_ANDI: op = ALU_AND;
            OP_ORI:  op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    assign state = r_state;

    // State register; async reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next;
        end
    end

    // Interrupt enable/pending; the INTR clear overrides a coincident set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_int_en      <= 1'b1;
            r_int_pending <= 1'b0;
        end else if (r_state == ST_INTR) begin
            r_int_en      <= 1'b0;
            r_int_pending <= 1'b0;
        end else begin
            r_int_en      <= (r_state == ST_ERET) ? 1'b1 : r_int_en;
            r_int_pending <= (INT && r_int_en) ? 1'b1 : r_int_pending;
        end
    end

    // Next-state decode and per-state datapath controls.
    always_comb begin
        w_next   = r_state;
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        CPU_MIO  = 1'b0;
        IRWrite  = 1'b0;
        EPCWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUop    = ALU_AND;
        PCSource = 3'b000;
        signal   = 1'b0;
        case (r_state)
            ST_IF: begin
                if (r_int_pending) begin
                    w_next = ST_INTR;
                end else begin
                    IorD    = 1'b0;
                    MemRead = 1'b1;
                    CPU_MIO = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUop   = ALU_ADD;
                    if (MIO_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = ST_ID;
                    end else begin
                        w_next  = ST_IF;
                    end
                end
            end
            ST_ID: begin
                ALUSrcB = 2'b11;
                ALUop   = ALU_ADD;
                case (opcode)
                    OP_RTYPE: w_next = (funct == FN_JR) ? ST_JR : ST_REX;
                    OP_LW, OP_SW: w_next = ST_MADR;
                    OP_BEQ, OP_BNE: w_next = ST_BR;
                    OP_J:     w_next = ST_JMP;
                    OP_JAL:   w_next = ST_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = ST_IEX;
                    OP_LUI:   w_next = ST_IWB;
                    OP_COP0:  w_next = (funct == FN_ERET) ? ST_ERET : ST_IF;
                    default:  w_next = ST_IF;
                endcase
            end
            ST_MADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = ALU_ADD;
                w_next  = (opcode == OP_SW) ? ST_MWR : ST_MRD;
            end
            ST_MRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                w_next  = MIO_ready ? ST_LWB : ST_MRD;
            end
            ST_LWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                w_next   = ST_IF;
            end
            ST_MWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                CPU_MIO  = 1'b1;
                w_next   = MIO_ready ? ST_IF : ST_MWR;
            end
            ST_REX: begin
                ALUSrcA = 1'b1;
                ALUop   = alu_from_funct(funct);
                w_next  = ST_RWB;
            end
            ST_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                w_next   = ST_IF;
            end
            ST_BR: begin
                ALUSrcA  = 1'b1;
                ALUop    = ALU_SUB;
                PCSource = 3'b001;
                PCWrite  = zero ^ (opcode == OP_BNE);
                w_next   = ST_IF;
            end
            ST_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 3'b010;
                w_next   = ST_IF;
            end
            ST_JAL: begin
                // PC already holds PC+4 from the fetch, so it is the link value.
                PCWrite  = 1'b1;
                PCSource = 3'b010;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                w_next   = ST_IF;
            end
            ST_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = alu_from_opcode(opcode);
                signal  = !((opcode == OP_ANDI) || (opcode == OP_ORI));
                w_next  = ST_IWB;
            end
            ST_IWB: begin
                RegWrite = 1'b1;
                MemtoReg = (opcode == OP_LUI) ? 2'b11 : 2'b00;
                w_next   = ST_IF;
            end
            ST_JR: begin
                PCWrite  = 1'b1;
                PCSource = 3'b011;
                w_next   = ST_IF;
            end
            ST_ERET: begin
                PCWrite  = 1'b1;
                PCSource = 3'b100;
                w_next   = ST_IF;
            end
            ST_INTR: begin
                EPCWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 3'b101;
                w_next   = ST_IF;
            end
            default: begin
                w_next = ST_IF;
            end
        endcase
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit that sequences the shared CPU datapath (single ALU, single memory port, register file, PC/EPC) one micro-step per clock. It decodes the latched instruction and steps an FSM through fetch, decode, execute, memory and write-back. It stalls on the memory handshake (`MIO_ready`) and takes external interrupts between instructions. The block drives every datapath mux select and write enable; it contains no datapath registers itself.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state.
- `opcode`  in  6  IR[31:26], stable from end of IF.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `MIO_ready`  in  1  memory access complete this cycle.
- `INT`  in  1  external interrupt request, level.
- `PCWrite`  out  1  PC load, branch decision already folded in.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemRead` / `MemWrite`  out  1 each  memory strobes.
- `CPU_MIO`  out  1  bus access active.
- `IRWrite`  out  1  IR and MDR load.
- `EPCWrite`  out  1  EPC <= PC.
- `RegWrite`  out  1  register-file write.
- `RegDst`  out  2  00 rt, 01 rd, 10 $31.
- `MemtoReg`  out  2  00 ALUOut, 01 MDR, 10 PC, 11 imm<<16.
- `ALUSrcA`  out  1  0 PC, 1 rs.
- `ALUSrcB`  out  2  00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2.
- `ALUop`  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
- `PCSource`  out  3  000 ALU, 001 ALUOut, 010 jump target, 011 rs, 100 EPC, 101 vector 0x0000_0004.
- `signal`  out  1  1 = sign-extend, 0 = zero-extend (andi, ori).
- `state`  out  4  current state, for debug.

## Operation
- States (encoding): IF 0, ID 1, MADR 2, MRD 3, LWB 4, MWR 5, REX 6, RWB 7, BR 8, JMP 9, IEX 10, IWB 11, JAL 12, JR 13, ERET 14, INTR 15.
- Outputs are a combinational function of state, opcode, funct, zero and MIO_ready. Unlisted outputs are 0.
- IF
  - Drives IorD=0, MemRead, CPU_MIO, ALUSrcA=0, ALUSrcB=01, add, PCSource=000.
  - IRWrite and PCWrite are asserted only when MIO_ready=1; the FSM goes to ID on ready, else holds.
  - Checked before the fetch: if int_pending=1, go to INTR and issue no memory access.
- ID
  - ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
  - Next state by opcode: R-type 000000 → REX (JR if funct 001000); lw 100011 / sw 101011 → MADR; beq 000100 / bne 000101 → BR; j 000010 → JMP; jal 000011 → JAL; addi 001000, slti 001010, andi 001100, ori 001101 → IEX; lui 001111 → IWB; eret (010000, funct 011000) → ERET.
  - Any other opcode → IF (executes as a nop).
- MADR: ALUSrcA=1, ALUSrcB=10, add; then MRD (lw) or MWR (sw).
- MRD: IorD=1, MemRead, CPU_MIO; holds until MIO_ready, then LWB.
- LWB: RegWrite, RegDst=00, MemtoReg=01 → IF.
- MWR: IorD=1, MemWrite, CPU_MIO; holds until MIO_ready, then IF.
- REX: ALUSrcA=1, ALUSrcB=00, ALUop from funct → RWB.
  - funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl.
- RWB: RegWrite, RegDst=01, MemtoReg=00 → IF.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCSource=001; PCWrite = zero XOR (opcode==bne) → IF.
- JMP: PCWrite, PCSource=010 → IF.
- JAL: PCWrite, PCSource=010, RegWrite, RegDst=10, MemtoReg=10 (PC already holds PC+4) → IF.
- IEX: ALUSrcA=1, ALUSrcB=10, ALUop add/slt/and/or per opcode, signal=0 for andi/ori → IWB.
- IWB: RegWrite, RegDst=00, MemtoReg=00 (11 for lui) → IF.
- JR: PCWrite, PCSource=011 → IF.
- ERET: PCWrite, PCSource=100; int_en <= 1 → IF.
- INTR: EPCWrite, PCWrite, PCSource=101; int_en <= 0, int_pending <= 0 → IF.
- Interrupt registers
  - int_pending is set on any clock with INT=1 && int_en=1.
  - If set and clear coincide (INTR), clear wins.

## Timing
- Reset (reset=0, async): state=IF, int_en=1, int_pending=0. state output is 0.
- Cycles per instruction at zero wait: beq/bne/j/jal/jr/eret/lui 3, R/I-ALU/sw 4, lw 5.
- Each MIO_ready=0 cycle in IF, MRD or MWR adds one cycle; all outputs stay constant while stalled.
- A write that depends on MIO_ready (IRWrite, PCWrite in IF) occurs exactly on the cycle MIO_ready=1.
- Interrupt latency: taken at the next IF after int_pending sets; an in-flight instruction always completes. INTR costs 1 cycle.
- INT asserted during INTR or before ERET (int_en=0) is ignored, not queued.
- Reset mid-instruction aborts immediately; no partial register write occurs after reset is asserted.

## Test plan
- Reset, then `add $3,$1,$2` with MIO_ready=1 → states 0,1,6,7,0; RWB shows RegWrite=1, RegDst=01; ALUop=010 in REX.
- `lw` with MIO_ready low for 2 cycles in MRD → states 0,1,2,3,3,3,4,0; MemRead and IorD stay 1 throughout MRD.
- `bne` with zero=1, then with zero=0 → PCWrite=0 in BR for the first, PCWrite=1 with PCSource=001 for the second.
- `jal` → JAL asserts PCWrite, RegWrite, RegDst=10, MemtoReg=10 in one cycle; 3 cycles total.
- INT pulsed during REX → instruction completes; next state is INTR with EPCWrite=1, PCSource=101. A second INT before eret is ignored. eret returns with PCSource=100 and re-enables interrupts.
- reset driven low during MRD stall → state reads 0 asynchronously; no RegWrite pulse; after release a fetch begins.
